// File: rtl/bcd_timekeeper.sv
// BCD HH:MM:SS time-of-day counter with range-checked load,
// 12-hour display view and minute/day carry pulses.
module bcd_timekeeper #(
  parameter bit         HAS_12H    = 1'b1,
  parameter logic [7:0] RESET_HOUR = 8'h00,
  parameter logic [7:0] RESET_MIN  = 8'h00,
  parameter logic [7:0] RESET_SEC  = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [1:0] hour_h_load_i,
  input  logic [3:0] hour_l_load_i,
  input  logic [2:0] minute_h_load_i,
  input  logic [3:0] minute_l_load_i,
  input  logic [2:0] second_h_load_i,
  input  logic [3:0] second_l_load_i,
  input  logic       mode_12h_i,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic [1:0] disp_hour_h_o,
  output logic [3:0] disp_hour_l_o,
  output logic       pm_o,
  output logic       min_tick_o,
  output logic       day_ovf_o,
  output logic       load_err_o,
  output logic       valid_o
);

  logic [1:0] hour_h;
  logic [3:0] hour_l;
  logic [2:0] min_h;
  logic [3:0] min_l;
  logic [2:0] sec_h;
  logic [3:0] sec_l;

  logic [1:0] nxt_hour_h;
  logic [3:0] nxt_hour_l;
  logic [2:0] nxt_min_h;
  logic [3:0] nxt_min_l;
  logic [2:0] nxt_sec_h;
  logic [3:0] nxt_sec_l;

  logic sec_l_c;
  logic sec_c;
  logic min_l_c;
  logic min_c;
  logic day_c;
  logic load_ok;

  logic min_tick;
  logic day_ovf;
  logic load_err;
  logic valid;

  // Whole carry chain resolved in one cycle from the current digits.
  always_comb begin
    sec_l_c = (sec_l == 4'd9);
    sec_c   = sec_l_c && (sec_h == 3'd5);
    min_l_c = sec_c && (min_l == 4'd9);
    min_c   = min_l_c && (min_h == 3'd5);
    day_c   = min_c && (hour_h == 2'd2) && (hour_l == 4'd3);

    nxt_sec_l = sec_l_c ? 4'd0 : sec_l + 4'd1;

    nxt_sec_h = sec_h;
    if (sec_c)
      nxt_sec_h = 3'd0;
    else if (sec_l_c)
      nxt_sec_h = sec_h + 3'd1;

    nxt_min_l = min_l;
    if (min_l_c)
      nxt_min_l = 4'd0;
    else if (sec_c)
      nxt_min_l = min_l + 4'd1;

    nxt_min_h = min_h;
    if (min_c)
      nxt_min_h = 3'd0;
    else if (min_l_c)
      nxt_min_h = min_h + 3'd1;

    nxt_hour_h = hour_h;
    nxt_hour_l = hour_l;
    if (day_c) begin
      nxt_hour_h = 2'd0;
      nxt_hour_l = 4'd0;
    end else if (min_c) begin
      if (hour_l == 4'd9) begin
        nxt_hour_h = hour_h + 2'd1;
        nxt_hour_l = 4'd0;
      end else begin
        nxt_hour_l = hour_l + 4'd1;
      end
    end
  end

  // Load is accepted only when every digit and the full hour are legal.
  always_comb begin
    load_ok = (hour_h_load_i <= 2'd2)
           && (hour_l_load_i <= 4'd9)
           && !((hour_h_load_i == 2'd2) && (hour_l_load_i > 4'd3))
           && (minute_h_load_i <= 3'd5)
           && (minute_l_load_i <= 4'd9)
           && (second_h_load_i <= 3'd5)
           && (second_l_load_i <= 4'd9);
  end

  // Time state, pulses and sticky valid; load takes priority over inc.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hour_h   <= RESET_HOUR[5:4];
      hour_l   <= RESET_HOUR[3:0];
      min_h    <= RESET_MIN[6:4];
      min_l    <= RESET_MIN[3:0];
      sec_h    <= RESET_SEC[6:4];
      sec_l    <= RESET_SEC[3:0];
      min_tick <= 1'b0;
      day_ovf  <= 1'b0;
      load_err <= 1'b0;
      valid    <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      day_ovf  <= 1'b0;
      load_err <= 1'b0;
      if (load_i) begin
        if (load_ok) begin
          hour_h <= hour_h_load_i;
          hour_l <= hour_l_load_i;
          min_h  <= minute_h_load_i;
          min_l  <= minute_l_load_i;
          sec_h  <= second_h_load_i;
          sec_l  <= second_l_load_i;
          valid  <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (inc_i) begin
        hour_h   <= nxt_hour_h;
        hour_l   <= nxt_hour_l;
        min_h    <= nxt_min_h;
        min_l    <= nxt_min_l;
        sec_h    <= nxt_sec_h;
        sec_l    <= nxt_sec_l;
        min_tick <= sec_c;
        day_ovf  <= day_c;
      end
    end
  end

  // 12-hour display view derived from the 24-hour state.
  always_comb begin
    disp_hour_h_o = hour_h;
    disp_hour_l_o = hour_l;
    pm_o          = 1'b0;
    if (HAS_12H) begin
      pm_o = (hour_h == 2'd2)
          || ((hour_h == 2'd1) && (hour_l >= 4'd2));
      if (mode_12h_i) begin
        if ((hour_h == 2'd0) && (hour_l == 4'd0)) begin
          disp_hour_h_o = 2'd1;
          disp_hour_l_o = 4'd2;
        end else if ((hour_h == 2'd1) && (hour_l >= 4'd3)) begin
          disp_hour_h_o = 2'd0;
          disp_hour_l_o = hour_l - 4'd2;
        end else if ((hour_h == 2'd2) && (hour_l <= 4'd1)) begin
          disp_hour_h_o = 2'd0;
          disp_hour_l_o = hour_l + 4'd8;
        end else if (hour_h == 2'd2) begin
          disp_hour_h_o = 2'd1;
          disp_hour_l_o = hour_l - 4'd2;
        end
      end
    end
  end

  assign hour_h_o   = hour_h;
  assign hour_l_o   = hour_l;
  assign minute_h_o = min_h;
  assign minute_l_o = min_l;
  assign second_h_o = sec_h;
  assign second_l_o = sec_l;
  assign min_tick_o = min_tick;
  assign day_ovf_o  = day_ovf;
  assign load_err_o = load_err;
  assign valid_o    = valid;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Scoreboard bench for bcd_timekeeper: directed steps push
// expected outputs, a negedge monitor pops and compares.
module tb_bcd_timekeeper;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       inc_i = 1'b0;
  logic       load_i = 1'b0;
  logic [1:0] hour_h_load_i = '0;
  logic [3:0] hour_l_load_i = '0;
  logic [2:0] minute_h_load_i = '0;
  logic [3:0] minute_l_load_i = '0;
  logic [2:0] second_h_load_i = '0;
  logic [3:0] second_l_load_i = '0;
  logic       mode_12h_i = 1'b0;
  logic [1:0] hour_h_o;
  logic [3:0] hour_l_o;
  logic [2:0] minute_h_o;
  logic [3:0] minute_l_o;
  logic [2:0] second_h_o;
  logic [3:0] second_l_o;
  logic [1:0] disp_hour_h_o;
  logic [3:0] disp_hour_l_o;
  logic       pm_o;
  logic       min_tick_o;
  logic       day_ovf_o;
  logic       load_err_o;
  logic       valid_o;

  bcd_timekeeper dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .inc_i(inc_i),
    .load_i(load_i),
    .hour_h_load_i(hour_h_load_i),
    .hour_l_load_i(hour_l_load_i),
    .minute_h_load_i(minute_h_load_i),
    .minute_l_load_i(minute_l_load_i),
    .second_h_load_i(second_h_load_i),
    .second_l_load_i(second_l_load_i),
    .mode_12h_i(mode_12h_i),
    .hour_h_o(hour_h_o),
    .hour_l_o(hour_l_o),
    .minute_h_o(minute_h_o),
    .minute_l_o(minute_l_o),
    .second_h_o(second_h_o),
    .second_l_o(second_l_o),
    .disp_hour_h_o(disp_hour_h_o),
    .disp_hour_l_o(disp_hour_l_o),
    .pm_o(pm_o),
    .min_tick_o(min_tick_o),
    .day_ovf_o(day_ovf_o),
    .load_err_o(load_err_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // {time bcd 24, disp 6, pm, tick, ovf, err, valid}
  typedef logic [34:0] exp_t;

  exp_t  q[$];
  string tq[$];
  int    checks = 0;
  int    failures = 0;
  int    ticks = 0;
  int    ovfs = 0;
  bit    counting = 1'b0;

  function automatic exp_t mk(input logic [23:0] t, input logic md,
                              input logic tk, input logic ov,
                              input logic er, input logic vl);
    int h;
    int d;
    logic [1:0] dh;
    logic [3:0] dl;
    logic pm;
    h = int'(t[21:20]) * 10 + int'(t[19:16]);
    d = h;
    if (md && h == 0)
      d = 12;
    else if (md && h > 12)
      d = h - 12;
    dh = 2'(d / 10);
    dl = 4'(d % 10);
    pm = (h >= 12);
    return {t, dh, dl, pm, tk, ov, er, vl};
  endfunction

  task automatic step(input logic r, input logic ld,
                      input logic in, input logic md,
                      input logic [23:0] lv,
                      input logic [23:0] et,
                      input logic tk, input logic ov,
                      input logic er, input logic vl,
                      input string tag);
    @(negedge clk);
    #1;
    rst_i = r;
    load_i = ld;
    inc_i = in;
    mode_12h_i = md;
    hour_h_load_i = lv[21:20];
    hour_l_load_i = lv[19:16];
    minute_h_load_i = lv[14:12];
    minute_l_load_i = lv[11:8];
    second_h_load_i = lv[6:4];
    second_l_load_i = lv[3:0];
    @(posedge clk);
    q.push_back(mk(et, md, tk, ov, er, vl));
    tq.push_back(tag);
  endtask

  // Monitor: compare DUT against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string tg;
    if (q.size() > 0) begin
      e = q.pop_front();
      tg = tq.pop_front();
      a = {2'b00, hour_h_o, hour_l_o,
           1'b0, minute_h_o, minute_l_o,
           1'b0, second_h_o, second_l_o,
           disp_hour_h_o, disp_hour_l_o,
           pm_o, min_tick_o, day_ovf_o, load_err_o, valid_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", tg, a, e);
      end
      if (counting) begin
        ticks += int'(min_tick_o);
        ovfs += int'(day_ovf_o);
      end
    end
  end

  initial begin
    int t;
    int h;
    int m;
    int s;
    logic [23:0] et;

    step(1,0,0,0, 24'h0, 24'h000000, 0,0,0,0, "reset");
    step(0,0,1,0, 24'h0, 24'h000001, 0,0,0,0, "inc1");
    step(1,0,1,0, 24'h0, 24'h000000, 0,0,0,0, "rst_over_inc");
    step(0,0,0,0, 24'h0, 24'h000000, 0,0,0,0, "idle");
    step(0,1,0,0, 24'h235959, 24'h235959, 0,0,0,1, "ld_235959");
    step(0,0,1,0, 24'h0, 24'h000000, 1,1,0,1, "day_wrap");
    step(0,0,0,0, 24'h0, 24'h000000, 0,0,0,1, "after_wrap");
    step(0,1,0,0, 24'h095959, 24'h095959, 0,0,0,1, "ld_095959");
    step(0,0,1,0, 24'h0, 24'h100000, 1,0,0,1, "h09_to_10");
    step(0,1,0,0, 24'h195959, 24'h195959, 0,0,0,1, "ld_195959");
    step(0,0,1,0, 24'h0, 24'h200000, 1,0,0,1, "h19_to_20");
    step(0,1,0,0, 24'h000059, 24'h000059, 0,0,0,1, "ld_000059");
    step(0,0,1,0, 24'h0, 24'h000100, 1,0,0,1, "min_carry");
    step(0,1,0,0, 24'h235959, 24'h235959, 0,0,0,1, "ld_235959b");
    step(0,1,1,0, 24'h000000, 24'h000000, 0,0,0,1, "ld_zero_no_tick");
    step(1,0,0,0, 24'h0, 24'h000000, 0,0,0,0, "reset2");
    step(0,1,0,0, 24'h240000, 24'h000000, 0,0,1,0, "bad_hour24");
    step(0,1,0,0, 24'h126000, 24'h000000, 0,0,1,0, "bad_min60");
    step(0,1,0,0, 24'h12000A, 24'h000000, 0,0,1,0, "bad_sec_l");
    step(0,1,0,0, 24'h0A0000, 24'h000000, 0,0,1,0, "bad_hour_l");
    step(0,0,0,0, 24'h0, 24'h000000, 0,0,0,0, "post_err");
    step(0,1,1,0, 24'h120000, 24'h120000, 0,0,0,1, "ld_with_inc");
    step(0,1,0,0, 24'h240000, 24'h120000, 0,0,1,1, "bad_keeps_valid");
    step(0,1,0,1, 24'h001500, 24'h001500, 0,0,0,1, "m12_00");
    step(0,1,0,1, 24'h121500, 24'h121500, 0,0,0,1, "m12_12");
    step(0,1,0,1, 24'h131500, 24'h131500, 0,0,0,1, "m12_13");
    step(0,1,0,1, 24'h231500, 24'h231500, 0,0,0,1, "m12_23");
    step(0,1,0,1, 24'h201500, 24'h201500, 0,0,0,1, "m12_20");
    step(0,1,0,1, 24'h091500, 24'h091500, 0,0,0,1, "m12_09");
    step(0,1,0,1, 24'h111500, 24'h111500, 0,0,0,1, "m12_11");
    step(0,0,0,0, 24'h0, 24'h111500, 0,0,0,1, "m24_11");
    step(0,1,0,0, 24'h131500, 24'h131500, 0,0,0,1, "m24_13");

    counting = 1'b1;
    step(0,1,0,0, 24'h000000, 24'h000000, 0,0,0,1, "ld_day_start");
    for (int i = 1; i <= 86400; i++) begin
      t = i % 86400;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      et = {2'b00, 2'(h / 10), 4'(h % 10),
            1'b0, 3'(m / 10), 4'(m % 10),
            1'b0, 3'(s / 10), 4'(s % 10)};
      step(0,0,1,0, 24'h0, et, (t % 60 == 0), (t == 0), 0,1, "day_run");
    end
    @(negedge clk);
    #1;
    inc_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    checks++;
    if (ticks != 1440) begin
      failures++;
      $display("FAIL min_tick_count got=%0d exp=1440", ticks);
    end
    checks++;
    if (ovfs != 1) begin
      failures++;
      $display("FAIL day_ovf_count got=%0d exp=1", ovfs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
